// File: rtl/cpu16_pkg.sv
// Shared cpu16 types: word type, memory arbiter state and grant encoding.
package cpu16_pkg;

   localparam int unsigned WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_INS  = 2'd1,
      ARB_DRD  = 2'd2,
      ARB_DWR  = 2'd3
   } arb_state_t;

   // One-hot arbitration result; all-zero means nobody is requesting.
   typedef struct packed {
      logic dwr;
      logic drd;
      logic ins;
   } arb_grant_t;

   localparam arb_grant_t GRANT_NONE = '0;

   // Busy state that services a given one-hot grant.
   function automatic arb_state_t grant_to_state(input arb_grant_t grant);
      arb_state_t st;
      st = ARB_IDLE;
      if (grant.dwr) begin
         st = ARB_DWR;
      end else if (grant.drd) begin
         st = ARB_DRD;
      end else if (grant.ins) begin
         st = ARB_INS;
      end
      return st;
   endfunction

endpackage

// File: rtl/cpu16_arb_pick.sv
// Combinational winner selector: store > load > fetch, except that a fetch
// wins outright once data has taken MAX_DAT_RUN grants in a row over it.
module cpu16_arb_pick
   import cpu16_pkg::*;
#(
   parameter int unsigned MAX_DAT_RUN = 4
) (
   input  logic                               ins_req,
   input  logic                               drd_req,
   input  logic                               dwr_req,
   input  logic [$clog2(MAX_DAT_RUN+1)-1:0]   dat_run,
   output arb_grant_t                         grant_c
);

   localparam int unsigned RUN_W = $clog2(MAX_DAT_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DAT_RUN);

   logic starved_c;

   // Fetch has been passed over the maximum number of times.
   assign starved_c = ins_req && (dat_run == RUN_MAX);

   // Priority chain producing a one-hot grant.
   always_comb begin
      grant_c = GRANT_NONE;
      if (starved_c) begin
         grant_c.ins = 1'b1;
      end else if (dwr_req) begin
         grant_c.dwr = 1'b1;
      end else if (drd_req) begin
         grant_c.drd = 1'b1;
      end else if (ins_req) begin
         grant_c.ins = 1'b1;
      end
   end

endmodule

// File: rtl/cpu16_mem_arb.sv
// Shares one req/ack memory port between the cpu16 fetch and load/store ports.
module cpu16_mem_arb
   import cpu16_pkg::*;
#(
   parameter int unsigned MAX_DAT_RUN = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] ins_rd_addr,
   input  logic        ins_rd_req,
   output logic [15:0] ins_rd_data,
   output logic        ins_rd_rdy,
   input  logic [15:0] dat_rw_addr,
   input  logic [15:0] dat_wr_data,
   input  logic        dat_rd_req,
   input  logic        dat_wr_req,
   output logic [15:0] dat_rd_data,
   output logic        dat_rd_rdy,
   output logic        dat_wr_rdy,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_req,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int unsigned RUN_W = $clog2(MAX_DAT_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DAT_RUN);

   arb_state_t       state_q, state_d;
   logic [RUN_W-1:0] dat_run_q, dat_run_d;
   word_t            mem_addr_q, mem_addr_d;
   word_t            mem_wdata_q, mem_wdata_d;
   logic             mem_we_q, mem_we_d;
   logic             mem_req_q, mem_req_d;
   word_t            ins_rd_data_q, ins_rd_data_d;
   logic             ins_rd_rdy_q, ins_rd_rdy_d;
   word_t            dat_rd_data_q, dat_rd_data_d;
   logic             dat_rd_rdy_q, dat_rd_rdy_d;
   logic             dat_wr_rdy_q, dat_wr_rdy_d;
   arb_grant_t       grant_c;

   cpu16_arb_pick #(
      .MAX_DAT_RUN (MAX_DAT_RUN)
   ) u_pick (
      .ins_req (ins_rd_req),
      .drd_req (dat_rd_req),
      .dwr_req (dat_wr_req),
      .dat_run (dat_run_q),
      .grant_c (grant_c)
   );

   // Next-state, grant latching, completion capture and fairness counter.
   always_comb begin
      state_d       = state_q;
      dat_run_d     = dat_run_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_we_d      = mem_we_q;
      mem_req_d     = mem_req_q;
      ins_rd_data_d = ins_rd_data_q;
      dat_rd_data_d = dat_rd_data_q;
      ins_rd_rdy_d  = 1'b0;
      dat_rd_rdy_d  = 1'b0;
      dat_wr_rdy_d  = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // mem_ack here belongs to nobody and is dropped.
            if (grant_c != GRANT_NONE) begin
               state_d   = grant_to_state(grant_c);
               mem_req_d = 1'b1;
               if (grant_c.ins) begin
                  mem_addr_d = ins_rd_addr;
                  mem_we_d   = 1'b0;
                  dat_run_d  = '0;
               end else begin
                  mem_addr_d = dat_rw_addr;
                  mem_we_d   = grant_c.dwr;
                  if (grant_c.dwr) begin
                     mem_wdata_d = dat_wr_data;
                  end
                  // Count only data grants that actually delay a fetch.
                  if (!ins_rd_req) begin
                     dat_run_d = '0;
                  end else if (dat_run_q != RUN_MAX) begin
                     dat_run_d = dat_run_q + RUN_W'(1);
                  end
               end
            end
         end

         ARB_INS: begin
            if (mem_ack) begin
               mem_req_d     = 1'b0;
               ins_rd_data_d = mem_rdata;
               ins_rd_rdy_d  = 1'b1;
               state_d       = ARB_IDLE;
            end
         end

         ARB_DRD: begin
            if (mem_ack) begin
               mem_req_d     = 1'b0;
               dat_rd_data_d = mem_rdata;
               dat_rd_rdy_d  = 1'b1;
               state_d       = ARB_IDLE;
            end
         end

         ARB_DWR: begin
            if (mem_ack) begin
               mem_req_d    = 1'b0;
               dat_wr_rdy_d = 1'b1;
               state_d      = ARB_IDLE;
            end
         end

         default: begin
            state_d   = ARB_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ARB_IDLE;
         dat_run_q     <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
         mem_req_q     <= 1'b0;
         ins_rd_data_q <= '0;
         ins_rd_rdy_q  <= 1'b0;
         dat_rd_data_q <= '0;
         dat_rd_rdy_q  <= 1'b0;
         dat_wr_rdy_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         dat_run_q     <= dat_run_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
         mem_req_q     <= mem_req_d;
         ins_rd_data_q <= ins_rd_data_d;
         ins_rd_rdy_q  <= ins_rd_rdy_d;
         dat_rd_data_q <= dat_rd_data_d;
         dat_rd_rdy_q  <= dat_rd_rdy_d;
         dat_wr_rdy_q  <= dat_wr_rdy_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;
   assign mem_req     = mem_req_q;
   assign ins_rd_data = ins_rd_data_q;
   assign ins_rd_rdy  = ins_rd_rdy_q;
   assign dat_rd_data = dat_rd_data_q;
   assign dat_rd_rdy  = dat_rd_rdy_q;
   assign dat_wr_rdy  = dat_wr_rdy_q;

endmodule
